result_display: RTL and testbench
=================================

Name: result_display

Overview:
- Output-side counterpart to the calculator's operand capture path: takes a finished 8-bit result and drives it to a 4-digit multiplexed seven-segment display.
- Converts binary to BCD sequentially (double-dabble, one shift per clock).
- Applies leading-zero blanking and a leading minus sign, shows an error pattern on request, and scans the four digits continuously.

Parameters:
- REFRESH_DIV, default 50000: clocks per digit slot; legal minimum 2; use 4 in simulation.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- value  input  8  unsigned result magnitude, 0..255
- negative  input  1  result sign; 1 shows a minus
- error  input  1  1 shows the error pattern instead of a number
- load  input  1  one-cycle strobe; sample value/negative/error
- busy  output  1  conversion in progress
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- an  output  4  digit enables, active-low; an[0] is rightmost

Behaviour:
- Reset (reset=0, asynchronous):
  - seg=7'b1111111, an=4'b1111, busy=0.
  - FSM goes to IDLE; refresh counter and digit index go to 0.
  - Displayed digits go to hundreds=0, tens=0, units=0, sign=0, err=0.
  - Reset mid-conversion aborts the conversion; the partial result is discarded.
- FSM states IDLE, CONVERT, UPDATE:
  - IDLE: on load=1, capture value, negative and error into shadow registers, clear the 12-bit BCD accumulator, set shift count=0, go to CONVERT. busy=1 from the next edge.
  - CONVERT: each cycle, add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1. After the 8th shift, go to UPDATE.
  - UPDATE: copy BCD and the flags into the displayed-digit registers, go to IDLE, busy=0.
  - Latency: load sampled at edge N gives displayed digits and busy=0 at edge N+10. busy is high for edges N+1..N+9.
  - load while busy=1 is ignored; there is no queueing.
  - load and reset together: reset wins.
- Scanning:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps. On wrap, the digit index increments mod 4 (3 wraps to 0).
  - an = one-hot low at the index, e.g. index 2 gives 4'b1011.
  - seg and an are registered and change together on the same edge. Scanning runs during conversion and keeps showing the old digits until UPDATE.
- Digit content (err=0):
  - an[0]: units, always shown.
  - an[1]: tens, blank if hundreds=0 and tens=0.
  - an[2]: hundreds, blank if 0.
  - an[3]: minus if sign=1, else blank.
  - A negative zero (value=0, negative=1) is shown without the minus sign.
- Digit content (err=1): an[3] blank, an[2]='E', an[1]='r', an[0]='r'. value and negative are ignored.
- Segment codes (gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - minus=0111111, E=0000110, r=0101111, blank=1111111
- Width rules: BCD accumulator is 12 bits; the maximum 255 fits. No overflow condition exists.

Test Plan:
- Release reset, wait 16 clocks (REFRESH_DIV=4) -> an cycles 1110,1101,1011,0111 at 4 clocks each. seg=1000000 on an[0] and 1111111 on the others. busy=0.
- load with value=8'd237, negative=0 -> busy high exactly 9 cycles, then an[2]/an[1]/an[0] show 0100100/0110000/1111000 and an[3] is blank.
- load with value=8'd7, negative=1 -> an[3]=0111111, an[2] and an[1] blank, an[0]=1111000. Then load with value=0, negative=1 -> only an[0]=1000000 is lit, no minus.
- load with error=1, value=8'd99 -> an[2]=0000110, an[1]=0101111, an[0]=0101111, an[3] blank.
- load 8'd255, then a second load with 8'd12 three cycles later -> second load ignored; display reads 255. busy still falls 9 cycles after the first load.
- load 8'd100, assert reset=0 at the 4th busy cycle, release -> busy=0, an=1111 while in reset, and the display then shows 0 with blanking, not 100.

Source files
------------

// File: rtl/result_display.sv
`default_nettype none
// ============================================================================
// Module   : result_display
// Purpose  : Takes a finished 8-bit calculator result (magnitude + sign +
//            error flag), converts it to BCD with a sequential double-dabble
//            (one shift per clock) and drives a 4-digit multiplexed,
//            active-low seven-segment display. Applies leading-zero blanking,
//            a leading minus sign, and an "Err" pattern.
// Ports    : clk       - system clock, rising edge
//            reset     - asynchronous active-low reset
//            value     - unsigned result magnitude 0..255
//            negative  - 1 shows a minus sign (suppressed for zero)
//            error     - 1 shows "Err" instead of a number
//            load      - one-cycle strobe sampling value/negative/error
//            busy      - conversion in progress
//            seg       - segments {g,f,e,d,c,b,a}, active-low
//            an        - digit enables, active-low, an[0] rightmost
// Revision : 1.0 - initial release
// ============================================================================
module result_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  input  logic       negative,
  input  logic       error,
  input  logic       load,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int         CNT_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } state_t;

  state_t             state_q,   state_d;
  logic [7:0]         bin_q,     bin_d;
  logic [11:0]        bcd_q,     bcd_d;
  logic [3:0]         shift_q,   shift_d;
  logic               sign_sh_q, sign_sh_d;
  logic               err_sh_q,  err_sh_d;
  logic [3:0]         hund_q,    hund_d;
  logic [3:0]         tens_q,    tens_d;
  logic [3:0]         units_q,   units_d;
  logic               sign_q,    sign_d;
  logic               err_q,     err_d;
  logic               busy_q,    busy_d;
  logic [CNT_W-1:0]   refresh_q, refresh_d;
  logic [1:0]         idx_q,     idx_d;
  logic [6:0]         seg_q,     seg_d;
  logic [3:0]         an_q,      an_d;

  logic [11:0]        bcd_adj;
  logic [19:0]        shifted;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'b1000000;
      4'd1:    dec7 = 7'b1111001;
      4'd2:    dec7 = 7'b0100100;
      4'd3:    dec7 = 7'b0110000;
      4'd4:    dec7 = 7'b0011001;
      4'd5:    dec7 = 7'b0010010;
      4'd6:    dec7 = 7'b0000010;
      4'd7:    dec7 = 7'b1111000;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0010000;
      default: dec7 = SEG_BLANK;
    endcase
  endfunction

  // Double-dabble step: correct every nibble >= 5, then shift {bcd,bin} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {bcd_adj, bin_q} << 1;
  end

  // Conversion FSM next state
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    shift_d   = shift_q;
    sign_sh_d = sign_sh_q;
    err_sh_d  = err_sh_q;
    hund_d    = hund_q;
    tens_d    = tens_q;
    units_d   = units_q;
    sign_d    = sign_q;
    err_d     = err_q;
    // busy trails the state by one edge so it covers exactly the nine cycles
    // from the edge after load through the UPDATE edge.
    busy_d    = (state_q == CONVERT);
    unique case (state_q)
      IDLE: begin
        if (load) begin
          bin_d     = value;
          bcd_d     = 12'd0;
          shift_d   = 4'd0;
          // A negative zero is displayed without the minus sign.
          sign_sh_d = negative & (|value);
          err_sh_d  = error;
          state_d   = CONVERT;
        end
      end
      CONVERT: begin
        if (shift_q == 4'd8) begin
          state_d = UPDATE;
        end else begin
          bcd_d   = shifted[19:8];
          bin_d   = shifted[7:0];
          shift_d = shift_q + 4'd1;
        end
      end
      UPDATE: begin
        hund_d  = bcd_q[11:8];
        tens_d  = bcd_q[7:4];
        units_d = bcd_q[3:0];
        sign_d  = sign_sh_q;
        err_d   = err_sh_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Digit scanning: seg/an are computed for the next digit index so both
  // registers switch on the same edge as the index.
  always_comb begin
    if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      idx_d     = idx_q + 2'd1;
    end else begin
      refresh_d = refresh_q + CNT_W'(1);
      idx_d     = idx_q;
    end
    an_d = ~(4'b0001 << idx_d);
    unique case (idx_d)
      2'd0:    seg_d = err_q ? SEG_R : dec7(units_q);
      2'd1:    seg_d = err_q ? SEG_R :
                       ((hund_q == 4'd0) && (tens_q == 4'd0)) ? SEG_BLANK : dec7(tens_q);
      2'd2:    seg_d = err_q ? SEG_E :
                       (hund_q == 4'd0) ? SEG_BLANK : dec7(hund_q);
      default: seg_d = (!err_q && sign_q) ? SEG_MINUS : SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bin_q     <= 8'd0;
      bcd_q     <= 12'd0;
      shift_q   <= 4'd0;
      sign_sh_q <= 1'b0;
      err_sh_q  <= 1'b0;
      hund_q    <= 4'd0;
      tens_q    <= 4'd0;
      units_q   <= 4'd0;
      sign_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      refresh_q <= '0;
      idx_q     <= 2'd0;
      seg_q     <= SEG_BLANK;
      an_q      <= 4'b1111;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      shift_q   <= shift_d;
      sign_sh_q <= sign_sh_d;
      err_sh_q  <= err_sh_d;
      hund_q    <= hund_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      sign_q    <= sign_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign busy = busy_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule
`default_nettype wire

// File: tb/tb_result_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_display
// Purpose  : Self-checking bench for result_display (REFRESH_DIV=4). A
//            decimal-level model predicts busy, the scanned digit enable and
//            the segment pattern every cycle; directed tests add literal
//            expectations for specific digits and busy length.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_display;

  localparam int         DIV   = 4;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;
  localparam logic [6:0] LTR_E = 7'b0000110;
  localparam logic [6:0] LTR_R = 7'b0101111;
  localparam logic [6:0] DIG [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] value = 8'd0;
  logic       negative = 1'b0;
  logic       error = 1'b0;
  logic       load = 1'b0;
  logic       busy;
  logic [6:0] seg;
  logic [3:0] an;

  int errors = 0;
  int checks = 0;

  result_display #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .negative (negative),
    .error    (error),
    .load     (load),
    .busy     (busy),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // e  : rising edges since reset release
  // ld : edge at which the last accepted load was sampled
  // disp_* : number held in the display; sh_* : number the seg register shows
  int e = 0;
  int ld = -100;
  bit pend = 0;
  int pend_v = 0;
  bit pend_neg = 0, pend_err = 0;
  int disp_v = 0;
  bit disp_neg = 0, disp_err = 0;
  int sh_v = 0;
  bit sh_neg = 0, sh_err = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      e = 0; ld = -100; pend = 0;
      disp_v = 0; disp_neg = 0; disp_err = 0;
      sh_v = 0; sh_neg = 0; sh_err = 0;
    end else begin
      e = e + 1;
      sh_v = disp_v; sh_neg = disp_neg; sh_err = disp_err;
      if (pend && e == ld + 10) begin
        disp_v = pend_v; disp_neg = pend_neg; disp_err = pend_err;
        pend = 0;
      end
      if (load && e > ld + 10) begin
        ld = e; pend = 1;
        pend_v = int'(value); pend_neg = negative; pend_err = error;
      end
    end
  end

  function automatic logic [6:0] exp_seg(input int slot, input int v, input bit neg, input bit er);
    if (er) begin
      if (slot == 3) return BLANK;
      else if (slot == 2) return LTR_E;
      else return LTR_R;
    end
    case (slot)
      0:       return DIG[v % 10];
      1:       return (v >= 10) ? DIG[(v / 10) % 10] : BLANK;
      2:       return (v >= 100) ? DIG[v / 100] : BLANK;
      default: return (neg && v != 0) ? MINUS : BLANK;
    endcase
  endfunction

  // ---------------- per-cycle compare ----------------
  logic [3:0] m_an;
  logic [6:0] m_seg;
  logic       m_busy;

  always @(negedge clk) begin
    if (!reset || e == 0) begin
      m_an  = 4'b1111;
      m_seg = BLANK;
    end else begin
      m_an  = ~(4'b0001 << ((e / DIV) % 4));
      m_seg = exp_seg((e / DIV) % 4, sh_v, sh_neg, sh_err);
    end
    m_busy = reset && (e >= ld + 1) && (e <= ld + 9);
    checks++;
    if (busy !== m_busy) begin
      errors++;
      $display("FAIL model_busy t=%0t: busy=%b required %b", $time, busy, m_busy);
    end
    checks++;
    if (an !== m_an) begin
      errors++;
      $display("FAIL model_an t=%0t: an=%b required %b", $time, an, m_an);
    end
    checks++;
    if (seg !== m_seg) begin
      errors++;
      $display("FAIL model_seg t=%0t: seg=%b required %b (an=%b)", $time, seg, m_seg, an);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic lit(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic lit_bits(input string name, input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  // Wait (bounded) until the given digit is enabled, then check its segments.
  task automatic check_slot(input int slot, input logic [6:0] req, input string name);
    logic [3:0] want;
    int n;
    want = ~(4'b0001 << slot);
    n = 0;
    @(posedge clk); #2;
    while (an !== want && n < 40) begin
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (an !== want) begin
      errors++;
      $display("FAIL %s: an=%b never reached required %b", name, an, want);
    end else if (seg !== req) begin
      errors++;
      $display("FAIL %s: seg=%b required %b", name, seg, req);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%b required 0 (timeout)", name, busy);
    end
    repeat (2) @(posedge clk);
  endtask

  // Issue a one-cycle load and measure busy; optionally try a second load
  // three edges after the first.
  task automatic load_count(input logic [7:0] v, input logic n, input logic er,
                            input bit two, input logic [7:0] v2, input string name);
    int cnt, first;
    @(posedge clk); #3;
    value = v; negative = n; error = er; load = 1'b1;
    @(posedge clk); #3;
    load = 1'b0;
    cnt = 0; first = -1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #2;
      if (busy === 1'b1) begin
        cnt++;
        if (first < 0) first = k;
      end
      if (two && k == 2) begin #1; value = v2; load = 1'b1; end
      if (two && k == 3) begin #1; load = 1'b0; end
    end
    lit({name, "_busy_len"}, cnt, 9);
    lit({name, "_busy_first"}, first, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;

    // Reset state and scan order with the default display (0)
    @(posedge clk); #2;
    lit("rst_an_slot0", int'(an), 4'b1110);
    lit_bits("rst_seg_units", seg, DIG[0]);
    lit("rst_busy", int'(busy), 0);
    repeat (4) @(posedge clk); #2;
    lit("rst_an_slot1", int'(an), 4'b1101);
    lit_bits("rst_seg_tens_blank", seg, BLANK);
    repeat (12) @(posedge clk);

    // 237 positive
    load_count(8'd237, 1'b0, 1'b0, 1'b0, 8'd0, "v237");
    wait_idle("v237_idle");
    check_slot(2, 7'b0100100, "v237_hund");
    check_slot(1, 7'b0110000, "v237_tens");
    check_slot(0, 7'b1111000, "v237_units");
    check_slot(3, BLANK,      "v237_sign");

    // -7
    load_count(8'd7, 1'b1, 1'b0, 1'b0, 8'd0, "vm7");
    wait_idle("vm7_idle");
    check_slot(3, MINUS,      "vm7_sign");
    check_slot(2, BLANK,      "vm7_hund");
    check_slot(1, BLANK,      "vm7_tens");
    check_slot(0, 7'b1111000, "vm7_units");

    // negative zero: no minus
    load_count(8'd0, 1'b1, 1'b0, 1'b0, 8'd0, "vm0");
    wait_idle("vm0_idle");
    check_slot(0, 7'b1000000, "vm0_units");
    check_slot(1, BLANK,      "vm0_tens");
    check_slot(3, BLANK,      "vm0_sign");

    // error pattern
    load_count(8'd99, 1'b0, 1'b1, 1'b0, 8'd0, "verr");
    wait_idle("verr_idle");
    check_slot(3, BLANK,      "verr_d3");
    check_slot(2, 7'b0000110, "verr_E");
    check_slot(1, 7'b0101111, "verr_r1");
    check_slot(0, 7'b0101111, "verr_r0");
    error = 1'b0;

    // 255 with an ignored second load of 12
    load_count(8'd255, 1'b0, 1'b0, 1'b1, 8'd12, "v255");
    wait_idle("v255_idle");
    check_slot(2, 7'b0100100, "v255_hund");
    check_slot(1, 7'b0010010, "v255_tens");
    check_slot(0, 7'b0010010, "v255_units");

    // 100, reset during the 4th busy cycle
    @(posedge clk); #3;
    value = 8'd100; negative = 1'b0; load = 1'b1;
    @(posedge clk); #3;
    load = 1'b0;
    repeat (4) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #2;
    lit("rstmid_busy", int'(busy), 0);
    lit("rstmid_an", int'(an), 4'b1111);
    lit_bits("rstmid_seg", seg, BLANK);
    #1 reset = 1'b1;
    repeat (12) @(posedge clk);
    lit("rstmid_busy_after", int'(busy), 0);
    check_slot(0, 7'b1000000, "rstmid_units");
    check_slot(1, BLANK,      "rstmid_tens");
    check_slot(2, BLANK,      "rstmid_hund");

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required < 200000", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
